step_responder: RTL

STEP_RESPONDER -- requirements
Module: step_responder

---
 rtl/step_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/step_responder.sv
// ---------------------------------------------------------------------------
// step_responder
//
// Watches the step code coming from the control unit and turns every step
// change into a single-cycle, one-hot datapath strobe. It also keeps its own
// count of completed iterations, cross-checks it against the control unit,
// and raises sticky flags for illegal step order, iteration disagreement and
// a stalled step sequence.
//
// Parameters
//   WDOG_LIMIT       cycles without a step change in RUN before stall is set
//   ITER_W           width of the iteration fields
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   step[3:0]        current step code from the control unit
//   change_iteration iteration-advance indication (counted on its rising edge)
//   done             run-complete indication
//   iteration        control unit's current iteration count
//   total_iteration  control unit's target iteration count
//   op_en[6:0]       one-hot strobes for steps 1..7 (bit0 = step 1)
//   iter_count       locally counted completed iterations (saturating)
//   busy             FSM is in RUN
//   finished         FSM is in DONE
//   seq_err          sticky illegal step order flag
//   iter_mismatch    sticky local/control-unit iteration disagreement flag
//   stall            sticky watchdog expiry flag
//
// Build option
//   STEP_ORDER_CHECK_EN  when defined, the step-order checker drives seq_err;
//                        otherwise seq_err is tied low and the checker is
//                        not built.
// ---------------------------------------------------------------------------
module step_responder #(
  parameter int WDOG_LIMIT = 255,
  parameter int ITER_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        step,
  input  logic              change_iteration,
  input  logic              done,
  input  logic [ITER_W-1:0] iteration,
  input  logic [ITER_W-1:0] total_iteration,
  output logic [6:0]        op_en,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              finished,
  output logic              seq_err,
  output logic              iter_mismatch,
  output logic              stall
);

  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        step_q;
  logic              chg_q;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_nxt;
  logic [6:0]        op_en_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic              entry;
  logic              strobe_code;
  logic              done_first;
  logic              chg_rise;
  logic              mismatch_set;

  // A step entry is any cycle where the incoming code differs from the one
  // captured on the previous edge. Only codes 1..7 map onto a strobe bit.
  assign entry       = (step != step_q);
  assign strobe_code = (step != 4'd0) && !step[3];
  assign done_first  = done && (state != DONE);
  assign chg_rise    = change_iteration && !chg_q;

  assign busy     = (state == RUN);
  assign finished = (state == DONE);

  // Next-state and strobe decode. done always wins: it moves the FSM to
  // DONE and suppresses any strobe that a simultaneous step entry would
  // otherwise have produced. Once in DONE nothing leaves except reset.
  always_comb begin
    state_nxt = state;
    op_en_nxt = '0;
    case (state)
      IDLE: begin
        if (done) begin
          state_nxt = DONE;
        end else if (entry && (step == 4'd1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if ((state != DONE) && !done && entry && strobe_code) begin
      op_en_nxt = 7'b1 << (step - 4'd1);
    end
  end

  // Local iteration count advances on change_iteration rising edges and
  // sticks at all-ones. The done-time comparison looks at this next value so
  // that an advance landing on the same edge as done is already included.
  always_comb begin
    iter_nxt = iter_count;
    if (chg_rise && (iter_count != '1)) begin
      iter_nxt = iter_count + ITER_W'(1);
    end
    mismatch_set = 1'b0;
    if ((state == RUN) && entry && (step == 4'd1) && (iteration != iter_count)) begin
      mismatch_set = 1'b1;
    end
    if (done_first && (iter_nxt != total_iteration)) begin
      mismatch_set = 1'b1;
    end
  end

  // Watchdog only moves while running: cleared by a step entry, otherwise
  // counting up until it reaches the limit, where it parks.
  always_comb begin
    wdog_nxt = wdog;
    if (state == RUN) begin
      if (entry) begin
        wdog_nxt = '0;
      end else if (wdog != WDOG_MAX) begin
        wdog_nxt = wdog + WDOG_W'(1);
      end
    end
  end

  // State register and all sequential bookkeeping. Reset clears everything,
  // including step_q, so the first cycle after release sees a step entry for
  // any nonzero code already present on the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      step_q        <= 4'd0;
      chg_q         <= 1'b0;
      op_en         <= '0;
      iter_count    <= '0;
      wdog          <= '0;
      iter_mismatch <= 1'b0;
      stall         <= 1'b0;
    end else begin
      state         <= state_nxt;
      step_q        <= step;
      chg_q         <= change_iteration;
      op_en         <= op_en_nxt;
      iter_count    <= iter_nxt;
      wdog          <= wdog_nxt;
      iter_mismatch <= iter_mismatch | mismatch_set;
      stall         <= stall | ((state == RUN) && (wdog_nxt == WDOG_MAX));
    end
  end

`ifdef STEP_ORDER_CHECK_EN
  logic seq_legal;
  logic seq_err_q;

  // Allowed moves: 0 from anywhere, 1 from 0 or 7, and k -> k+1 for k in
  // 1..6. Everything else, including any move onto 8..15, is an error.
  always_comb begin
    seq_legal = 1'b0;
    if (step == 4'd0) begin
      seq_legal = 1'b1;
    end else if ((step == 4'd1) && ((step_q == 4'd0) || (step_q == 4'd7))) begin
      seq_legal = 1'b1;
    end else if ((step_q >= 4'd1) && (step_q <= 4'd6) && (step == step_q + 4'd1)) begin
      seq_legal = 1'b1;
    end
  end

  // Sticky order-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else if (entry && !seq_legal) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule
